// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the memory-stage load/store unit.
// Misalignment trapping is enabled in lsu_ctrl by LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } lsu_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Reserved encodings fall through to word size.
  function automatic lsu_size_e size_of(input logic [2:0] f3);
    lsu_size_e s;
    case (f3)
      F3_LB, F3_LBU: s = BYTE;
      F3_LH, F3_LHU: s = HALF;
      F3_LW:         s = WORD;
      default:       s = WORD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-enable generation, store lane replication and
// load extract/extend. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_e   st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  lsu_size_e   ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_uns_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = st_data_i;
    unique case (st_size_i)
      BYTE: begin
        be_o    = 4'b0001 << st_off_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      HALF: begin
        be_o    = 4'b0011 << {st_off_i[1], 1'b0};
        wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    b = rdata_i[7:0];
    unique case (ld_off_i)
      2'd0: b = rdata_i[7:0];
      2'd1: b = rdata_i[15:8];
      2'd2: b = rdata_i[23:16];
      2'd3: b = rdata_i[31:24];
      default: ;
    endcase
    h = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    ld_data_o = rdata_i;
    unique case (ld_size_i)
      BYTE: ld_data_o = ld_uns_i ? {24'b0, b} : {{24{b[7]}}, b};
      HALF: ld_data_o = ld_uns_i ? {16'b0, h} : {{16{h[15]}}, h};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: memory-stage LSU, one req/gnt/rvalid transaction at a time.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic              we_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] st_data_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] ld_data_o,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic              misalign_o,
`endif
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  if (DATA_W != 32) begin : g_bad_dw
    $error("lsu_ctrl: DATA_W must be 32");
  end

  lsu_state_e        state_q, state_d;
  lsu_size_e         size_q, size_d, size_in;
  logic [1:0]        off_q, off_d, off_in;
  logic              uns_q, uns_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d, be_w;
  logic [31:0]       wdata_q, wdata_d, wdata_w;
  logic [31:0]       ld_q, ld_d, ld_w;
  logic              done_q, done_d;
  logic              mis_in;
  logic              mis_q, mis_d;

  assign size_in = size_of(funct3_i);

  always_comb begin
    off_in = 2'b00;
    unique case (size_in)
      BYTE:    off_in = addr_i[1:0];
      HALF:    off_in = {addr_i[1], 1'b0};
      default: off_in = 2'b00;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_in = (size_in == HALF && addr_i[0]) ||
                  (size_in == WORD && addr_i[1:0] != 2'b00);
`else
  assign mis_in = 1'b0;
`endif

  lsu_align u_align (
    .st_size_i (size_in),
    .st_off_i  (off_in),
    .st_data_i (st_data_i),
    .be_o      (be_w),
    .wdata_o   (wdata_w),
    .ld_size_i (size_q),
    .ld_off_i  (off_q),
    .ld_uns_i  (uns_q),
    .rdata_i   (mem_rdata_i),
    .ld_data_o (ld_w)
  );

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    off_d   = off_q;
    uns_d   = uns_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    ld_d    = ld_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // done_q marks the still-presented finished op; don't re-accept it
        if (valid_i && !done_q) begin
          if (mis_in) begin
            done_d = 1'b1;
            mis_d  = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = we_i;
            addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
            be_d    = be_w;
            wdata_d = wdata_w;
            size_d  = size_in;
            off_d   = off_in;
            uns_d   = funct3_i[2];
          end
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          req_d = 1'b0;
          if (we_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          ld_d    = ld_w;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      size_q  <= BYTE;
      off_q   <= 2'b00;
      uns_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0;
      wdata_q <= 32'b0;
      ld_q    <= 32'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      off_q   <= off_d;
      uns_q   <= uns_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
    end
  end

  assign stall_o     = rst_ni & valid_i & ~done_q;
  assign done_o      = done_q;
  assign ld_data_o   = ld_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_o  = mis_q;
`else
  logic unused_mis;
  assign unused_mis  = mis_q;
`endif

endmodule
